// File: rtl/varint_enc_n.sv
// Protobuf varint encoder: pops DATA_W-bit words, pushes LSB-first 7-bit groups at one byte per cycle.
// Optional build macro VARINT_ZIGZAG_EN adds varint_zigzag_mode for sint zigzag mapping of each popped word.
module varint_enc_n #(
  parameter int DATA_W  = 64,
  parameter int COUNT_W = 32,
  localparam int MAX_BYTES = (DATA_W + 6) / 7,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               varint_in_fifo_empty,
  output logic               varint_in_fifo_pop,
  output logic               varint_in_index_pop,
  input  logic [DATA_W-1:0]  varint_data_in,
`ifdef VARINT_ZIGZAG_EN
  input  logic               varint_zigzag_mode,
`endif
  input  logic               varint_out_fifo_full,
  output logic               varint_out_fifo_clr,
  output logic               varint_out_fifo_push,
  output logic               varint_out_index_clr,
  output logic               varint_out_index_push,
  output logic [7:0]         varint_data_out,
  output logic               varint_out_last,
  output logic [LEN_W-1:0]   varint_out_len,
  output logic [COUNT_W-1:0] varint_count
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0]  load_val;
  logic               more;

`ifdef VARINT_ZIGZAG_EN
  assign load_val = varint_zigzag_mode
                  ? ((varint_data_in << 1) ^ {DATA_W{varint_data_in[DATA_W-1]}})
                  : varint_data_in;
`else
  assign load_val = varint_data_in;
`endif

  assign more = (sh_q >> 7) != '0;

  always_comb begin
    state_d              = state_q;
    sh_d                 = sh_q;
    cnt_d                = cnt_q;
    count_d              = count_q;
    varint_in_fifo_pop   = 1'b0;
    varint_out_fifo_push = 1'b0;
    varint_out_fifo_clr  = 1'b0;
    varint_data_out      = '0;
    varint_out_last      = 1'b0;
    varint_out_len       = '0;
    case (state_q)
      INIT: begin
        varint_out_fifo_clr = 1'b1;
        state_d             = IDLE;
      end
      IDLE: begin
        if (!varint_in_fifo_empty) begin
          varint_in_fifo_pop = 1'b1;
          sh_d               = load_val;
          cnt_d              = '0;
          state_d            = EMIT;
        end
      end
      EMIT: begin
        // A full output FIFO freezes sh/cnt so the pending byte is re-offered.
        if (!varint_out_fifo_full) begin
          varint_out_fifo_push = 1'b1;
          varint_data_out      = {more, sh_q[6:0]};
          if (more) begin
            sh_d  = sh_q >> 7;
            cnt_d = cnt_q + LEN_W'(1);
          end else begin
            varint_out_last = 1'b1;
            varint_out_len  = cnt_q + LEN_W'(1);
            count_d         = count_q + COUNT_W'(1);
            // Chain straight into the next word to avoid a bubble between varints.
            if (!varint_in_fifo_empty) begin
              varint_in_fifo_pop = 1'b1;
              sh_d               = load_val;
              cnt_d              = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
    if (reset) begin
      varint_in_fifo_pop   = 1'b0;
      varint_out_fifo_push = 1'b0;
      varint_out_fifo_clr  = 1'b0;
      varint_data_out      = '0;
      varint_out_last      = 1'b0;
      varint_out_len       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      sh_q    <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign varint_in_index_pop   = varint_in_fifo_pop;
  assign varint_out_index_push = varint_out_fifo_push;
  assign varint_out_index_clr  = varint_out_fifo_clr;
  assign varint_count          = reset ? '0 : count_q;

endmodule

// File: tb/tb_varint_enc_n.sv
// Scoreboard bench for varint_enc_n: directed words with hand-computed byte streams,
// a FIFO model feeding the DUT and a monitor comparing every pushed byte.
module tb_varint_enc_n;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [3:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        empty = 1'b1, full = 1'b0;
  logic [63:0] data_in = '0;
  logic        zz_mode = 1'b0;
  logic        pop, ipop, clr, iclr, push, ipush, last;
  logic [7:0]  dout;
  logic [3:0]  len;
  logic [31:0] count;

  logic        empty32 = 1'b1, pop32_seen = 1'b0;
  logic [31:0] data32 = '0;
  logic        pop32, ipop32, clr32, iclr32, push32, ipush32, last32;
  logic [7:0]  dout32;
  logic [2:0]  len32;
  logic [31:0] count32;

  logic [63:0] in_q [$];
  logic        zz_q [$];
  exp_t        exp_q [$];
  exp_t        exp32_q [$];

  int n_vec = 0, n_err = 0;
  int cycle = 0, n_push = 0, n_pop = 0, n_clr = 0;
  int p_first = 0, p_last = 0, p_cnt = 0;

  always #5 clk = ~clk;

  varint_enc_n #(.DATA_W(64), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .varint_in_fifo_empty(empty), .varint_in_fifo_pop(pop), .varint_in_index_pop(ipop),
    .varint_data_in(data_in),
`ifdef VARINT_ZIGZAG_EN
    .varint_zigzag_mode(zz_mode),
`endif
    .varint_out_fifo_full(full), .varint_out_fifo_clr(clr), .varint_out_fifo_push(push),
    .varint_out_index_clr(iclr), .varint_out_index_push(ipush),
    .varint_data_out(dout), .varint_out_last(last), .varint_out_len(len),
    .varint_count(count)
  );

  varint_enc_n #(.DATA_W(32), .COUNT_W(32)) dut32 (
    .clk(clk), .reset(reset),
    .varint_in_fifo_empty(empty32), .varint_in_fifo_pop(pop32), .varint_in_index_pop(ipop32),
    .varint_data_in(data32),
`ifdef VARINT_ZIGZAG_EN
    .varint_zigzag_mode(1'b0),
`endif
    .varint_out_fifo_full(1'b0), .varint_out_fifo_clr(clr32), .varint_out_fifo_push(push32),
    .varint_out_index_clr(iclr32), .varint_out_index_push(ipush32),
    .varint_data_out(dout32), .varint_out_last(last32), .varint_out_len(len32),
    .varint_count(count32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic e(input logic [7:0] b, input logic l, input logic [3:0] n);
    exp_t x;
    x.b = b; x.last = l; x.len = n;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [63:0] w, input logic zz);
    in_q.push_back(w);
    zz_q.push_back(zz);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0 || exp32_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", (k >= 300), 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pushes(input int target);
    int k = 0;
    while (n_push < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("push_wait_timeout", (k >= 100), 1'b0);
  endtask

  // Input FIFO model: present head word (show-ahead) from each falling edge.
  always @(negedge clk) begin
    empty   = (in_q.size() == 0);
    data_in = empty ? 64'd0 : in_q[0];
    zz_mode = empty ? 1'b0 : zz_q[0];
    if (pop32_seen) begin
      empty32    = 1'b1;
      pop32_seen = 1'b0;
    end
  end

  // Monitor: sample 1 time unit before each rising edge.
  always @(negedge clk) begin
    exp_t x;
    #4;
    cycle++;
    if (reset) begin
      chk("rst_strobes", {58'd0, pop, ipop, push, ipush, clr, iclr}, 64'd0);
      chk("rst_outputs", {51'd0, dout, last, len}, 64'd0);
      chk("rst_count", {32'd0, count}, 64'd0);
    end
    if (clr) n_clr++;
    if (clr || iclr) chk("index_clr", iclr, clr);
    if (full) chk("stall_no_push", push, 1'b0);
    if (pop) begin
      n_pop++;
      chk("index_pop", ipop, 1'b1);
      chk("pop_nonempty", empty, 1'b0);
      if (in_q.size() > 0) begin
        void'(in_q.pop_front());
        void'(zz_q.pop_front());
      end
    end
    if (push) begin
      n_push++;
      if (p_cnt == 0) p_first = cycle;
      p_last = cycle;
      p_cnt++;
      chk("index_push", ipush, 1'b1);
      chk("push_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("byte", {56'd0, dout}, {56'd0, x.b});
        chk("last", {63'd0, last}, {63'd0, x.last});
        chk("len", {60'd0, len}, {60'd0, x.len});
      end
    end else if (!reset) begin
      chk("idle_outputs", {51'd0, dout, last, len}, 64'd0);
    end
    if (pop32) pop32_seen = 1'b1;
    if (push32) begin
      chk("push32_expected", (exp32_q.size() != 0), 1'b1);
      if (exp32_q.size() != 0) begin
        x = exp32_q.pop_front();
        chk("byte32", {56'd0, dout32}, {56'd0, x.b});
        chk("last32", {63'd0, last32}, {63'd0, x.last});
        chk("len32", {61'd0, len32}, {61'd0, x.len[2:0]});
      end
    end
  end

  initial begin
    int pop0, push0, clr0;
    exp_t x;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_clr_once", n_clr, 1);

    // 300, 127, 128 back-to-back
    e(8'hAC, 0, 0); e(8'h02, 1, 2);
    e(8'h7F, 1, 1);
    e(8'h80, 0, 0); e(8'h01, 1, 2);
    send(64'd300, 0); send(64'd127, 0); send(64'd128, 0);
    wait_drain();
    chk("count_a", count, 3);

    // 0 then 2^64-1 with no bubble
    p_cnt = 0; pop0 = n_pop;
    e(8'h00, 1, 1);
    for (int i = 0; i < 9; i++) e(8'hFF, 0, 0);
    e(8'h01, 1, 10);
    send(64'd0, 0); send({64{1'b1}}, 0);
    wait_drain();
    chk("b2b_push_count", p_cnt, 11);
    chk("b2b_consecutive", p_last - p_first, 10);
    chk("b2b_pops", n_pop - pop0, 2);
    chk("count_b", count, 5);

    // 16384 with 3 stalled cycles after the first byte
    push0 = n_push;
    e(8'h80, 0, 0); e(8'h80, 0, 0); e(8'h01, 1, 3);
    send(64'd16384, 0);
    wait_pushes(push0 + 1);
    full = 1'b1;
    repeat (3) @(negedge clk);
    full = 1'b0;
    wait_drain();
    chk("stall_push_count", n_push - push0, 3);
    chk("count_c", count, 6);

    // reset during the second byte of 2^35
    push0 = n_push;
    e(8'h80, 0, 0);
    send(64'h8_0000_0000, 0);
    wait_pushes(push0 + 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_abandon_push", n_push - push0, 1);
    exp_q.delete();
    clr0 = n_clr;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reinit_clr_once", n_clr - clr0, 1);
    e(8'h05, 1, 1);
    send(64'd5, 0);
    wait_drain();
    chk("count_d", count, 1);

    // 32-bit instance, 0xFFFFFFFF
    for (int i = 0; i < 4; i++) begin
      x.b = 8'hFF; x.last = 0; x.len = 0;
      exp32_q.push_back(x);
    end
    x.b = 8'h0F; x.last = 1; x.len = 5;
    exp32_q.push_back(x);
    @(negedge clk);
    data32  = 32'hFFFF_FFFF;
    empty32 = 1'b0;
    wait_drain();
    chk("count32", count32, 1);

`ifdef VARINT_ZIGZAG_EN
    e(8'h01, 1, 1); e(8'h02, 1, 1); e(8'h03, 1, 1); e(8'h01, 1, 1);
    send({64{1'b1}}, 1); send(64'd1, 1); send(64'hFFFF_FFFF_FFFF_FFFE, 1); send(64'd1, 0);
    wait_drain();
    chk("count_zz", count, 5);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/varint_enc_n.md
Name: varint_enc_n

Overview:
Parametrised protobuf varint encoder: next generation of the fsm_2 one-byte-at-a-time encoder. Pops DATA_W-bit unsigned words from a show-ahead input FIFO and pushes LSB-first 7-bit groups with continuation bit 7 into a byte-wide output FIFO. Sustains one byte per cycle, including back-to-back varints. Adds last-byte and length reporting plus a completed-varint counter.

Parameters:
DATA_W, 64, input word width; legal 8..64.
COUNT_W, 32, width of completed-varint counter.
(localparam) MAX_BYTES = ceil(DATA_W/7), LEN_W = clog2(MAX_BYTES+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
varint_in_fifo_empty  in  1  input FIFO empty (show-ahead)
varint_in_fifo_pop  out  1  consume head word
varint_in_index_pop  out  1  companion index pop, equals varint_in_fifo_pop
varint_data_in  in  DATA_W  head word, valid when empty=0
varint_out_fifo_full  in  1  output FIFO full
varint_out_fifo_clr  out  1  clear output FIFO
varint_out_fifo_push  out  1  push varint_data_out
varint_out_index_clr  out  1  clear output index
varint_out_index_push  out  1  companion push, equals varint_out_fifo_push
varint_data_out  out  8  encoded byte
varint_out_last  out  1  final byte of current varint, valid with push
varint_out_len  out  LEN_W  byte count of varint, valid with push & last, else 0
varint_count  out  COUNT_W  completed varints since reset, wraps

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- While reset=1:
  - all strobes are 0: pop, push, clr.
  - varint_data_out, last and len are 0; varint_count is 0.
  - state is INIT.
- INIT (exactly 1 cycle after reset drops): out_fifo_clr=1, out_index_clr=1; go IDLE.
- IDLE:
  - if empty=0: pop=1 and load sh <= varint_data_in (same-cycle sample); cnt <= 0; go EMIT.
  - otherwise stay in IDLE.
- EMIT:
  - byte = {more, sh[6:0]}, where more = (sh>>7)!=0.
  - full=1: no push; hold sh/cnt; stay (stall, no byte lost).
  - full=0: push=1, data_out=byte, last=~more.
  - full=0, more=1: sh <= sh>>7, cnt <= cnt+1; stay in EMIT.
  - full=0, more=0: len=cnt+1, varint_count++.
    - if empty=0: pop next word in the same cycle, reload sh, cnt <= 0; stay in EMIT (no bubble).
    - else go IDLE.
- Output timing: data_out, last and len are combinational from sh/cnt/state; meaningful only when push=1, otherwise 0.
- Edge cases:
  - Value 0 encodes to the single byte 0x00, last=1, len=1.
  - Max length is MAX_BYTES (64-bit: 10 bytes).
  - Word bits above DATA_W do not exist; shifting is logical.
- Reset mid-varint: the partial varint is abandoned. INIT clears the output FIFO and index, so no orphan bytes remain. varint_count restarts at 0.
- Input pop and output push can coincide only on the last byte.
- Illegal state encoding → INIT.

Optional Feature:
- Macro VARINT_ZIGZAG_EN.
- When defined:
  - adds input port varint_zigzag_mode (1 bit), sampled with each pop.
  - when that bit is 1, the loaded value is (x<<1) ^ {DATA_W{x[DATA_W-1]}}, i.e. sint zigzag encoding.
- When undefined: the port is absent and words are encoded as raw unsigned.

Test Plan:
- DATA_W=64, push 300 → bytes 0xAC (last=0), 0x02 (last=1, len=2); count=1.
- Push 0 then 2^64-1 back-to-back → 0x00 (len=1), then 9×0xFF + 0x01 (len=10). Pushes occur on 11 consecutive cycles; exactly one pop per word; count=2.
- Push 16384 with full forced high for 3 cycles after the first byte → 0x80, (stall), 0x80, 0x01. No push while full; no duplicate bytes.
- Reset asserted during the 2nd byte of 2^35 → strobes 0 during reset, then 1 INIT cycle with clr=1. Next input 5 → single byte 0x05; count=1.
- DATA_W=32, push 0xFFFFFFFF → 0xFF×4, 0x0F (len=5).
- VARINT_ZIGZAG_EN, mode=1, inputs -1, 1, -2 → 0x01, 0x02, 0x03. Mode=0 with 1 → 0x01.
